// File: rtl/vga_game_pkg.sv
// rtl/vga_game_pkg.sv - shared game state type, screen defaults and obstacle reset placement
package vga_game_pkg;

    localparam int H_ACTIVE_DEFAULT = 640;
    localparam int V_ACTIVE_DEFAULT = 480;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } game_state_t;

    // Staggered start: obstacles spread evenly across the lane, each lane
    // offset by one obstacle width so lanes do not line up vertically.
    function automatic int reset_x(input int k, input int lane, input int h_active,
                                   input int objs, input int obj_w);
        return (k * (h_active / objs) + lane * obj_w) % h_active;
    endfunction

endpackage

// File: rtl/obstacle_lane.sv
// rtl/obstacle_lane.sv - one lane of scrolling obstacles with wrap-aware pixel hit test
//
// Ports:
//   i_clk, i_reset         pixel clock, synchronous active-high reset
//   i_move                 advance all obstacles of this lane by STEP
//   i_dir                  0 = rightward, 1 = leftward
//   i_counter_x/y          current scan position
//   o_lane_hit             combinational: scan position lies on an obstacle of this lane
module obstacle_lane
    import vga_game_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEFAULT,
    parameter int OBJS       = 2,
    parameter int OBJ_W      = 20,
    parameter int LANE_Y0    = 56,
    parameter int LANE_PITCH = 64,
    parameter int LANE_H     = 8,
    parameter int STEP       = 2,
    parameter int COORD_W    = 10,
    parameter int LANE       = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_move,
    input  logic               i_dir,
    input  logic [COORD_W-1:0] i_counter_x,
    input  logic [COORD_W-1:0] i_counter_y,
    output logic               o_lane_hit
);

    localparam int ROW0 = LANE_Y0 + LANE * LANE_PITCH;

    localparam logic [COORD_W:0] H_E     = (COORD_W+1)'(H_ACTIVE);
    localparam logic [COORD_W:0] STEP_E  = (COORD_W+1)'(STEP);
    localparam logic [COORD_W:0] OBJW_M1 = (COORD_W+1)'(OBJ_W - 1);
    localparam logic [COORD_W:0] ROW_LO  = (COORD_W+1)'(ROW0);
    localparam logic [COORD_W:0] ROW_HI  = (COORD_W+1)'(ROW0 + LANE_H - 1);

    logic [COORD_W-1:0] r_x    [OBJS];
    logic [COORD_W-1:0] w_next [OBJS];
    logic               w_col_hit;
    logic               w_row_hit;
    logic [COORD_W:0]   w_cx;
    logic [COORD_W:0]   w_cy;

    assign w_cx = {1'b0, i_counter_x};
    assign w_cy = {1'b0, i_counter_y};

    // All arithmetic is one bit wider than the coordinates so that the
    // unwrapped right edge (up to H_ACTIVE+OBJ_W-2) and x+STEP never overflow.
    always_comb begin
        logic [COORD_W:0] x_ext;
        logic [COORD_W:0] x_end;
        logic [COORD_W:0] sum;
        w_col_hit = 1'b0;
        for (int k = 0; k < OBJS; k++) begin
            x_ext = {1'b0, r_x[k]};
            sum   = x_ext + STEP_E;
            if (!i_dir) begin
                w_next[k] = (sum >= H_E) ? COORD_W'(sum - H_E) : COORD_W'(sum);
            end else begin
                w_next[k] = (x_ext < STEP_E) ? COORD_W'(x_ext + H_E - STEP_E)
                                             : COORD_W'(x_ext - STEP_E);
            end
            x_end = x_ext + OBJW_M1;
            if ((w_cx >= x_ext) && (w_cx <= x_end)) begin
                w_col_hit = 1'b1;
            end
            // Obstacle straddling the right edge also covers the leftmost columns.
            if ((x_end >= H_E) && (w_cx <= (x_end - H_E))) begin
                w_col_hit = 1'b1;
            end
        end
    end

    assign w_row_hit  = (w_cy >= ROW_LO) && (w_cy <= ROW_HI);
    assign o_lane_hit = w_row_hit & w_col_hit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < OBJS; k++) begin
                r_x[k] <= COORD_W'(reset_x(k, LANE, H_ACTIVE, OBJS, OBJ_W));
            end
        end else if (i_move) begin
            for (int k = 0; k < OBJS; k++) begin
                r_x[k] <= w_next[k];
            end
        end
    end

endmodule

// File: rtl/obstacle_field_engine.sv
// rtl/obstacle_field_engine.sv - obstacle lanes, player box render, per-frame hit detection and game FSM
//
// Ports:
//   i_clk, i_reset          pixel clock, synchronous active-high reset
//   i_start                 level: IDLE->PLAY, OVER->IDLE
//   i_move_tick             one-cycle pulse advancing obstacles (PLAY only)
//   i_frame_start           one-cycle pulse at first vertical-blank cycle
//   i_dir_mask              per-lane direction, 1 = leftward
//   i_counter_x/y           scan position, i_in_display visible flag
//   i_player_x/y            player box centre
//   o_pix_obstacle/player   registered pixel flags, one cycle behind the scan
//   o_hit_pulse             frame just closed contained an overlap
//   o_hit_count             saturating hit counter
//   o_state                 00 IDLE, 01 PLAY, 10 OVER
module obstacle_field_engine
    import vga_game_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEFAULT,
    parameter int NUM_LANES   = 6,
    parameter int OBJS        = 2,
    parameter int OBJ_W       = 20,
    parameter int LANE_Y0     = 56,
    parameter int LANE_PITCH  = 64,
    parameter int LANE_H      = 8,
    parameter int STEP        = 2,
    parameter int PLAYER_HALF = 30,
    parameter int COORD_W     = 10,
    parameter int MAX_HITS    = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_move_tick,
    input  logic                 i_frame_start,
    input  logic [NUM_LANES-1:0] i_dir_mask,
    input  logic [COORD_W-1:0]   i_counter_x,
    input  logic [COORD_W-1:0]   i_counter_y,
    input  logic                 i_in_display,
    input  logic [COORD_W-1:0]   i_player_x,
    input  logic [COORD_W-1:0]   i_player_y,
    output logic                 o_pix_obstacle,
    output logic                 o_pix_player,
    output logic                 o_hit_pulse,
    output logic [3:0]           o_hit_count,
    output logic [1:0]           o_state
);

    localparam logic [COORD_W:0] PH = (COORD_W+1)'(PLAYER_HALF);

    game_state_t          r_state;
    logic                 r_frame_hit;
    logic [3:0]           r_hit_count;
    logic                 r_hit_pulse;
    logic                 r_pix_obstacle;
    logic                 r_pix_player;

    logic [NUM_LANES-1:0] w_lane_hit;
    logic                 w_obs_hit;
    logic                 w_player_hit;
    logic                 w_overlap;
    logic                 w_move;
    logic                 w_in_play;
    logic [COORD_W:0]     w_cx;
    logic [COORD_W:0]     w_cy;
    logic [COORD_W:0]     w_px;
    logic [COORD_W:0]     w_py;

    assign w_in_play = (r_state == PLAY);
    assign w_move    = i_move_tick & w_in_play;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        obstacle_lane #(
            .H_ACTIVE  (H_ACTIVE),
            .OBJS      (OBJS),
            .OBJ_W     (OBJ_W),
            .LANE_Y0   (LANE_Y0),
            .LANE_PITCH(LANE_PITCH),
            .LANE_H    (LANE_H),
            .STEP      (STEP),
            .COORD_W   (COORD_W),
            .LANE      (l)
        ) u_lane (
            .i_clk      (i_clk),
            .i_reset    (i_reset),
            .i_move     (w_move),
            .i_dir      (i_dir_mask[l]),
            .i_counter_x(i_counter_x),
            .i_counter_y(i_counter_y),
            .o_lane_hit (w_lane_hit[l])
        );
    end

    assign w_obs_hit = |w_lane_hit;

    // Widened so a box near the screen origin never wraps to the far edge.
    assign w_cx = {1'b0, i_counter_x};
    assign w_cy = {1'b0, i_counter_y};
    assign w_px = {1'b0, i_player_x};
    assign w_py = {1'b0, i_player_y};

    assign w_player_hit = ((w_cx + PH) >= w_px) && (w_cx <= (w_px + PH)) &&
                          ((w_cy + PH) >= w_py) && (w_cy <= (w_py + PH));

    assign w_overlap = i_in_display & w_obs_hit & w_player_hit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_frame_hit    <= 1'b0;
            r_hit_count    <= 4'd0;
            r_hit_pulse    <= 1'b0;
            r_pix_obstacle <= 1'b0;
            r_pix_player   <= 1'b0;
        end else begin
            r_pix_obstacle <= i_in_display & w_obs_hit;
            r_pix_player   <= i_in_display & w_player_hit;
            r_hit_pulse    <= i_frame_start & r_frame_hit;

            // An overlap coinciding with frame_start opens the new frame.
            if (i_frame_start) begin
                r_frame_hit <= w_overlap & w_in_play;
                if (r_frame_hit && (r_hit_count != 4'hF)) begin
                    r_hit_count <= r_hit_count + 4'd1;
                end
            end else if (w_overlap && w_in_play) begin
                r_frame_hit <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= PLAY;
                        r_hit_count <= 4'd0;
                        r_frame_hit <= 1'b0;
                    end
                end
                PLAY: begin
                    if (r_hit_count >= 4'(MAX_HITS)) begin
                        r_state <= OVER;
                    end
                end
                OVER: begin
                    if (i_start) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_pix_obstacle = r_pix_obstacle;
    assign o_pix_player   = r_pix_player;
    assign o_hit_pulse    = r_hit_pulse;
    assign o_hit_count    = r_hit_count;
    assign o_state        = r_state;

endmodule

// File: tb/tb_obstacle_field_engine.sv
// tb/tb_obstacle_field_engine.sv - directed self-checking bench for obstacle_field_engine
module tb_obstacle_field_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       move_tick;
    logic       frame_start;
    logic [5:0] dir_mask;
    logic [9:0] counter_x;
    logic [9:0] counter_y;
    logic       in_display;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic       pix_obstacle;
    logic       pix_player;
    logic       hit_pulse;
    logic [3:0] hit_count;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    obstacle_field_engine dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_start       (start),
        .i_move_tick   (move_tick),
        .i_frame_start (frame_start),
        .i_dir_mask    (dir_mask),
        .i_counter_x   (counter_x),
        .i_counter_y   (counter_y),
        .i_in_display  (in_display),
        .i_player_x    (player_x),
        .i_player_y    (player_y),
        .o_pix_obstacle(pix_obstacle),
        .o_pix_player  (pix_player),
        .o_hit_pulse   (hit_pulse),
        .o_hit_count   (hit_count),
        .o_state       (state)
    );

    task automatic chk(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan(input int cx, input int cy, input logic disp);
        counter_x  = 10'(cx);
        counter_y  = 10'(cy);
        in_display = disp;
        tick();
    endtask

    task automatic pix_chk(input string tag, input int cx, input int cy,
                           input int exp_obs, input int exp_pl);
        scan(cx, cy, 1'b1);
        chk({tag, "_obs"}, int'(pix_obstacle), exp_obs);
        chk({tag, "_pl"}, int'(pix_player), exp_pl);
    endtask

    task automatic move(input int n);
        for (int i = 0; i < n; i++) begin
            move_tick = 1'b1;
            tick();
            move_tick = 1'b0;
            tick();
        end
    endtask

    task automatic frame_pulse();
        counter_x   = 10'd0;
        counter_y   = 10'd0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        move_tick   = 1'b0;
        frame_start = 1'b0;
        dir_mask    = 6'b0;
        counter_x   = 10'd0;
        counter_y   = 10'd0;
        in_display  = 1'b0;
        player_x    = 10'd600;
        player_y    = 10'd470;
        tick();
        tick();
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(hit_count), 0);
        chk("rst_pulse", int'(hit_pulse), 0);
        chk("rst_pix_obs", int'(pix_obstacle), 0);
        chk("rst_pix_pl", int'(pix_player), 0);
        reset = 1'b0;

        // reset placement: lane0 {0,320}, lane1 {20,340}
        pix_chk("l0o0_c0", 0, 56, 1, 0);
        pix_chk("l0o0_c19", 19, 56, 1, 0);
        pix_chk("l0o0_c20", 20, 56, 0, 0);
        pix_chk("l0o1_c320", 320, 56, 1, 0);
        pix_chk("l1o0_c20", 20, 120, 1, 0);
        pix_chk("l1o0_c19", 19, 120, 0, 0);
        pix_chk("l0_row55", 0, 55, 0, 0);
        pix_chk("l0_row63", 0, 63, 1, 0);
        pix_chk("l0_row64", 0, 64, 0, 0);
        scan(0, 56, 1'b0);
        chk("disp_gate", int'(pix_obstacle), 0);

        // moves ignored outside PLAY
        move(1);
        pix_chk("idle_frozen", 0, 56, 1, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("play_state", int'(state), 1);

        move(5);
        pix_chk("r10_c9", 9, 56, 0, 0);
        pix_chk("r10_c10", 10, 56, 1, 0);
        pix_chk("r10_c29", 29, 56, 1, 0);
        pix_chk("r10_c30", 30, 56, 0, 0);

        move(315);
        pix_chk("wrap0_c0", 0, 56, 1, 0);
        pix_chk("wrap0_c639", 639, 56, 0, 0);
        pix_chk("wrap0_c19", 19, 56, 1, 0);
        pix_chk("wrap0_c20", 20, 56, 0, 0);

        dir_mask = 6'b000001;
        move(1);
        pix_chk("l638_c637", 637, 56, 0, 0);
        pix_chk("l638_c638", 638, 56, 1, 0);
        pix_chk("l638_c17", 17, 56, 1, 0);
        pix_chk("l638_c18", 18, 56, 0, 0);

        move(4);
        pix_chk("l630_c629", 629, 56, 0, 0);
        pix_chk("l630_c630", 630, 56, 1, 0);
        pix_chk("l630_c639", 639, 56, 1, 0);
        pix_chk("l630_c0", 0, 56, 1, 0);
        pix_chk("l630_c9", 9, 56, 1, 0);
        counter_x = 10'd10;
        #2;
        chk("lag_hold", int'(pix_obstacle), 1);
        tick();
        chk("lag_c10", int'(pix_obstacle), 0);

        player_x = 10'd10;
        player_y = 10'd10;
        pix_chk("pl_c0", 0, 10, 0, 1);
        pix_chk("pl_c40", 40, 10, 0, 1);
        pix_chk("pl_c41", 41, 10, 0, 0);
        pix_chk("pl_c639", 639, 10, 0, 0);
        pix_chk("pl_r40", 10, 40, 0, 1);
        pix_chk("pl_r41", 10, 41, 0, 0);

        // lane3 obstacles now at 70 and 390; player covers x 370..430, y 220..280
        player_x = 10'd400;
        player_y = 10'd250;
        frame_pulse();
        chk("nohit_pulse", int'(hit_pulse), 0);
        chk("nohit_count", int'(hit_count), 0);

        counter_x   = 10'd400;
        counter_y   = 10'd250;
        in_display  = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("fs_ovl_pulse", int'(hit_pulse), 0);
        chk("fs_ovl_count", int'(hit_count), 0);
        scan(0, 0, 1'b1);
        frame_pulse();
        chk("next_pulse", int'(hit_pulse), 1);
        chk("next_count", int'(hit_count), 1);
        tick();
        chk("pulse_once", int'(hit_pulse), 0);

        for (int n = 2; n <= 10; n++) begin
            scan(400, 250, 1'b1);
            frame_pulse();
            chk($sformatf("hit%0d_pulse", n), int'(hit_pulse), 1);
            chk($sformatf("hit%0d_count", n), int'(hit_count), n);
        end
        chk("max_still_play", int'(state), 1);
        tick();
        chk("over_state", int'(state), 2);

        move(1);
        pix_chk("frz_c389", 389, 248, 0, 1);
        pix_chk("frz_c390", 390, 248, 1, 1);
        pix_chk("frz_c409", 409, 248, 1, 1);
        pix_chk("frz_c410", 410, 248, 0, 1);
        frame_pulse();
        chk("over_no_pulse", int'(hit_pulse), 0);
        chk("over_count", int'(hit_count), 10);

        start = 1'b1;
        tick();
        start = 1'b0;
        chk("over_to_idle", int'(state), 0);
        chk("idle_count", int'(hit_count), 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("idle_to_play", int'(state), 1);
        chk("play_clr_count", int'(hit_count), 0);

        // overlap sets frame_hit, then reset (with move_tick) discards it
        scan(400, 250, 1'b1);
        reset     = 1'b1;
        move_tick = 1'b1;
        tick();
        reset     = 1'b0;
        move_tick = 1'b0;
        chk("mid_rst_state", int'(state), 0);
        chk("mid_rst_count", int'(hit_count), 0);
        chk("mid_rst_pulse", int'(hit_pulse), 0);
        frame_pulse();
        chk("mid_rst_fs_pulse", int'(hit_pulse), 0);
        chk("mid_rst_fs_count", int'(hit_count), 0);
        pix_chk("rst_l3_c59", 59, 248, 0, 0);
        pix_chk("rst_l3_c60", 60, 248, 1, 0);
        pix_chk("rst_l3_c380", 380, 248, 1, 1);
        pix_chk("rst_l0_c0", 0, 56, 1, 0);
        pix_chk("rst_l0_c639", 639, 56, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
